// File: rtl/calc_key_sequencer_if.sv
// Keypad-to-ALU handshake bundle: key stream in, operation stream out, plus status.
// The slave modport is the sequencer side; the master modport drives keys and sinks operations.
interface calc_key_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             key_valid_i;
  logic [3:0]       key_code_i;
  logic             key_ready_o;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic [1:0]       fct_o;
  logic             op_valid_o;
  logic             op_ready_i;
  logic             err_o;

  modport slave (
    input  key_valid_i, key_code_i, op_ready_i,
    output key_ready_o, a_o, b_o, fct_o, op_valid_o, err_o
  );

  modport master (
    output key_valid_i, key_code_i, op_ready_i,
    input  key_ready_o, a_o, b_o, fct_o, op_valid_o, err_o
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Keypad sequencer: builds decimal operands A/B and an operator, then issues one
// ALU operation per '=' over a registered valid/ready handshake.
module calc_key_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  calc_key_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_OP    = 2'd1,
    S_B     = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_fct;
  logic             r_valid;
  logic             r_err;
  logic             r_key_ready;

  logic             w_accept;
  logic             w_is_digit;
  logic             w_is_op;
  logic             w_is_eq;
  logic             w_is_clr;
  logic [1:0]       w_fct;
  logic [WIDTH-1:0] w_acc;
  logic [WIDTH+3:0] w_new;
  logic             w_ovf;

  assign w_accept   = bus.key_valid_i & r_key_ready;
  assign w_is_digit = (bus.key_code_i <= 4'd9);
  assign w_is_op    = (bus.key_code_i >= 4'd10) && (bus.key_code_i <= 4'd13);
  assign w_is_eq    = (bus.key_code_i == 4'd14);
  assign w_is_clr   = (bus.key_code_i == 4'd15);
  assign w_fct      = 2'(bus.key_code_i - 4'd10);

  // Only one operand accumulates at a time; the wide sum exposes overflow in its top nibble.
  assign w_acc = (r_state == S_B) ? r_b : r_a;
  assign w_new = ((WIDTH+4)'(w_acc) * (WIDTH+4)'(10)) + (WIDTH+4)'(bus.key_code_i);
  assign w_ovf = |w_new[WIDTH+3:WIDTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_A;
      r_a         <= '0;
      r_b         <= '0;
      r_fct       <= 2'b00;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_key_ready <= 1'b1;
    end else if (r_state == S_ISSUE) begin
      if (bus.op_ready_i) begin
        r_state     <= S_A;
        r_a         <= '0;
        r_b         <= '0;
        r_fct       <= 2'b00;
        r_valid     <= 1'b0;
        r_err       <= 1'b0;
        r_key_ready <= 1'b1;
      end
    end else if (w_accept) begin
      if (w_is_clr) begin
        r_state <= S_A;
        r_a     <= '0;
        r_b     <= '0;
        r_fct   <= 2'b00;
        r_err   <= 1'b0;
      end else if (w_is_digit) begin
        case (r_state)
          S_OP: begin
            r_b     <= WIDTH'(bus.key_code_i);
            r_state <= S_B;
          end
          S_B: begin
            if (w_ovf) r_err <= 1'b1;
            else       r_b   <= w_new[WIDTH-1:0];
          end
          default: begin
            if (w_ovf) r_err <= 1'b1;
            else       r_a   <= w_new[WIDTH-1:0];
          end
        endcase
      end else if (w_is_op) begin
        // Operators after B has started are dropped so the pending operation stays intact.
        if (r_state != S_B) begin
          r_fct   <= w_fct;
          r_state <= S_OP;
        end
      end else if (w_is_eq) begin
        if (r_state == S_B) begin
          r_state     <= S_ISSUE;
          r_valid     <= 1'b1;
          r_key_ready <= 1'b0;
        end
      end
    end
  end

  assign bus.key_ready_o = r_key_ready;
  assign bus.a_o         = r_a;
  assign bus.b_o         = r_b;
  assign bus.fct_o       = r_fct;
  assign bus.op_valid_o  = r_valid;
  assign bus.err_o       = r_err;

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Front-end stage of the calculator datapath, sitting directly upstream of the ALU.
- Consumes a stream of keypad codes and builds two unsigned decimal operands plus an operator.
- On '=' it issues one ALU operation (a, b, fct) through a valid/ready handshake.
- Operand registers are continuously visible, so the display path can echo entry in progress.

Parameters:
- WIDTH, 8, operand width in bits; matches the ALU operand width.

Ports:
- clk_i  input  1  system clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- key_valid_i  input  1  key code present
- key_code_i  input  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 cmp, 14 equals, 15 clear
- key_ready_o  output  1  sequencer can accept a key
- a_o  output  WIDTH  operand A register
- b_o  output  WIDTH  operand B register
- fct_o  output  2  operator for ALU: 00 add, 01 sub, 10 mul, 11 compare
- op_valid_o  output  1  a_o/b_o/fct_o form a complete operation
- op_ready_i  input  1  ALU stage accepts the operation
- err_o  output  1  sticky digit-overflow flag

Behaviour:
- Reset: asynchronous on rst_ni low; takes effect immediately, including mid-issue.
  - a_o=0, b_o=0, fct_o=00, op_valid_o=0, err_o=0, state S_A, key_ready_o=1.
- Key acceptance: key accepted on a rising edge with key_valid_i & key_ready_o. Registers and state update on that same edge. Keys presented while key_ready_o=0 are ignored, not queued.
- key_ready_o = 1 in S_A, S_OP, S_B; 0 in S_ISSUE.
- Digit accumulation: new = acc*10 + d, computed at WIDTH+4 bits.
  - If new > 2^WIDTH-1: digit rejected, accumulator unchanged, err_o set.
  - Otherwise acc <= new[WIDTH-1:0].
- Operator keys 10-13 map to fct 00/01/10/11 respectively.
- FSM states:
  - S_A: digit -> accumulate into A. Operator -> latch fct, go S_OP; A may be 0 if no digit was entered. Equals -> ignored.
  - S_OP: digit d -> b <= d, go S_B. Operator -> overwrite fct, stay. Equals -> ignored.
  - S_B: digit -> accumulate into B. Operator -> ignored. Equals -> go S_ISSUE.
  - S_ISSUE: op_valid_o=1; a_o, b_o, fct_o held stable. On an edge with op_ready_i=1: a<=0, b<=0, fct<=00, err_o<=0, op_valid_o<=0, go S_A.
- Clear (15): accepted in S_A, S_OP, S_B.
  - Same register values as reset: a=b=0, fct=00, err_o=0, go S_A.
  - Not accepted in S_ISSUE, because key_ready_o is low there.
- Latency:
  - op_valid_o rises on the edge that accepts '=', so it is high the following cycle.
  - op_valid_o falls on the edge where op_ready_i is sampled high.
  - Minimum issue occupancy is 1 cycle if op_ready_i is already high.
- op_valid_o is registered. Once high it must not drop and operands must not change until the handshake completes.
- err_o: set by a rejected digit in either operand. Cleared only by reset, clear, or a completed issue. It does not block issue.
- All arithmetic is unsigned. No negative entry.
- Invalid codes are not possible, since all 16 codes are defined.

Test Plan (WIDTH=8, op_ready_i=1 unless stated):
- Keys 1,5,10,5,14 -> op_valid_o high on the cycle after '=' with a_o=15, b_o=5, fct_o=00. Following cycle: op_valid_o=0, a_o=b_o=0, key_ready_o=1.
- Same sequence with op_ready_i held 0 for 3 cycles -> op_valid_o, a_o=15, b_o=5 stable and key_ready_o=0. A key 7 presented during stall has no effect. Raising op_ready_i completes the issue in one edge.
- Overflow cases:
  - Keys 2,5,5 -> a_o=255, err_o=0.
  - After clear, keys 2,5,6 -> a_o=25, err_o=1.
  - Then 10,3,14 issues a=25, b=3 and err_o returns to 0 after the handshake.
- Keys 3,10,12,2,14 -> fct_o=10, a_o=3, b_o=2. A further key 11 presented while in S_B is ignored, so fct stays 10.
- Ignored/clear keys:
  - Key 14 in S_A and again in S_OP -> no state change, op_valid_o stays 0.
  - Keys 4,11,9 then 15 -> a_o=b_o=0, fct_o=00, state S_A.
- Drive rst_ni low asynchronously (between clock edges) while op_valid_o=1 -> op_valid_o, a_o, b_o drop to 0 immediately. After release, key_ready_o=1 and digit entry works normally.
